// File: rtl/semaforo_pkg.sv
// semaforo_pkg: shared debounce FSM state type and default timing constants
package semaforo_pkg;
  typedef enum logic [1:0] {SOLTO, CONFIRMA_ALTO, PRESSIONADO, CONFIRMA_BAIXO} estado_db_t;
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int REPEAT_CYCLES_DEF = 8;
  localparam int SYNC_STAGES_DEF = 2;
endpackage

// File: rtl/debounce_pulso_sincronizador.sv
// sincronizador: SYNC_STAGES-deep flop chain bringing async d into clk domain (clk, reset sync active-high, d in, q out)
module sincronizador #(
  parameter int SYNC_STAGES = semaforo_pkg::SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] s;
  always_ff @(posedge clk)
    if (reset) s <= '0;
    else s <= {s[SYNC_STAGES-2:0], d};
  assign q = s[SYNC_STAGES-1];
endmodule

// File: rtl/debounce_pulso.sv
// debounce_pulso: sync+debounce raw botao into one-cycle pulso per press and level estavel (clk, reset sync active-high, botao in, pulso/estavel out); AUTO_REPEAT_EN adds held-button repeat pulses
module debounce_pulso
  import semaforo_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int CNT_W = $clog2((DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic botao,
  output logic pulso,
  output logic estavel
);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_MAX = CNT_W'(REPEAT_CYCLES - 1);
`endif
  logic b_s;
  estado_db_t est, est_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic pulso_n, estavel_n;
  sincronizador #(.SYNC_STAGES(SYNC_STAGES)) u_sinc (.clk(clk), .reset(reset), .d(botao), .q(b_s));
  always_comb begin
    est_n = est;
    cnt_n = cnt;
    pulso_n = 1'b0;
    estavel_n = estavel;
    case (est)
      SOLTO:
        if (b_s) begin
          est_n = CONFIRMA_ALTO;
          cnt_n = CNT_W'(1);
        end else cnt_n = '0;
      CONFIRMA_ALTO:
        if (!b_s) begin
          est_n = SOLTO;
          cnt_n = '0;
        end else if (cnt == DEB_MAX) begin
          est_n = PRESSIONADO;
          pulso_n = 1'b1;
          estavel_n = 1'b1;
          cnt_n = '0;
        end else cnt_n = cnt + 1'b1;
      PRESSIONADO:
        if (!b_s) begin
          est_n = CONFIRMA_BAIXO;
          cnt_n = CNT_W'(1);
        end
`ifdef AUTO_REPEAT_EN
        else if (cnt == REP_MAX) begin
          pulso_n = 1'b1;
          cnt_n = '0;
        end else cnt_n = cnt + 1'b1;
`else
        else cnt_n = '0;
`endif
      CONFIRMA_BAIXO:
        if (b_s) begin
          est_n = PRESSIONADO;
          cnt_n = '0;
        end else if (cnt == DEB_MAX) begin
          est_n = SOLTO;
          estavel_n = 1'b0;
          cnt_n = '0;
        end else cnt_n = cnt + 1'b1;
      default: begin
        est_n = SOLTO;
        cnt_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      est <= SOLTO;
      cnt <= '0;
      pulso <= 1'b0;
      estavel <= 1'b0;
    end else begin
      est <= est_n;
      cnt <= cnt_n;
      pulso <= pulso_n;
      estavel <= estavel_n;
    end
endmodule
